// File: rtl/seg7_to_bcd_capture.sv
// Seven-segment display scraper: debounces multiplexed digit strobes,
// decodes each slot to BCD and presents full 4-digit frames via valid/ready.
module seg7_to_bcd_capture #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  seg_in,
  input  logic [3:0]  dig_sel,
  output logic [15:0] bcd_out,
  output logic [3:0]  err_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        overrun
);

  typedef enum logic {
    COLLECT,
    PRESENT
  } state_e;

  // The counter holds matches seen, i.e. run length minus one.
  localparam logic [7:0] SAT     = 8'(STABLE_CYCLES);
  localparam logic [7:0] FIRE_AT = 8'(STABLE_CYCLES - 2);

  logic [6:0]  seg_q;
  logic [3:0]  sel_q;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] dig_q;
  logic [3:0]  serr_q;
  logic [3:0]  filled_q;
  logic [15:0] bcd_q;
  logic [3:0]  err_q;
  logic        ovr_q;
  state_e      state_q;

  logic        onehot;
  logic        match;
  logic        fire;
  logic [4:0]  dec;

  function automatic logic [4:0] seg_dec(input logic [6:0] s);
    logic [4:0] r;
    case (s)
      7'b1111110: r = 5'h00;
      7'b0110000: r = 5'h01;
      7'b1101101: r = 5'h02;
      7'b1111001: r = 5'h03;
      7'b0110011: r = 5'h04;
      7'b1011011: r = 5'h05;
      7'b1011111: r = 5'h06;
      7'b1110000: r = 5'h07;
      7'b1111111: r = 5'h08;
      7'b1111011: r = 5'h09;
      default:    r = 5'h1F;
    endcase
    return r;
  endfunction

  // Run detection and capture strobe.
  always_comb begin
    onehot = (dig_sel != 4'd0) &&
             ((dig_sel & (dig_sel - 4'd1)) == 4'd0);
    match  = onehot && (seg_in == seg_q) &&
             (dig_sel == sel_q);
    fire   = match && (cnt_q == FIRE_AT);
    dec    = seg_dec(seg_in);
    cnt_d  = 8'd0;
    if (match) begin
      cnt_d = (cnt_q == SAT) ? cnt_q : cnt_q + 8'd1;
    end
  end

  // Input sampling and stability counter, active in both states.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q <= 7'd0;
      sel_q <= 4'd0;
      cnt_q <= 8'd0;
    end else begin
      seg_q <= seg_in;
      sel_q <= dig_sel;
      cnt_q <= cnt_d;
    end
  end

  // Slot storage, frame FSM and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= COLLECT;
      dig_q    <= 16'd0;
      serr_q   <= 4'd0;
      filled_q <= 4'd0;
      bcd_q    <= 16'd0;
      err_q    <= 4'd0;
      ovr_q    <= 1'b0;
    end else begin
      ovr_q <= fire && (state_q == PRESENT);
      unique case (state_q)
        COLLECT: begin
          for (int i = 0; i < 4; i++) begin
            if (fire && dig_sel[i]) begin
              dig_q[i*4 +: 4] <= dec[3:0];
              serr_q[i]       <= dec[4];
              filled_q[i]     <= 1'b1;
            end
          end
          if (filled_q == 4'hF) begin
            state_q <= PRESENT;
            bcd_q   <= dig_q;
            err_q   <= serr_q;
          end
        end
        PRESENT: begin
          if (out_ready) begin
            state_q  <= COLLECT;
            filled_q <= 4'd0;
          end
        end
        default: state_q <= COLLECT;
      endcase
    end
  end

  assign bcd_out   = bcd_q;
  assign err_out   = err_q;
  assign out_valid = (state_q == PRESENT);
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_seg7_to_bcd_capture.sv
// Randomised and directed bench for seg7_to_bcd_capture against a
// run-length / frame reference model.
module tb_seg7_to_bcd_capture;

  localparam int N = 4;

  logic        clk;
  logic        rst_n;
  logic [6:0]  seg_in;
  logic [3:0]  dig_sel;
  logic [15:0] bcd_out;
  logic [3:0]  err_out;
  logic        out_valid;
  logic        out_ready;
  logic        overrun;

  seg7_to_bcd_capture #(.STABLE_CYCLES(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .seg_in    (seg_in),
    .dig_sel   (dig_sel),
    .bcd_out   (bcd_out),
    .err_out   (err_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_pass;

  logic [6:0] pat [10];

  // reference model state
  int         run_len;
  logic [6:0] prev_seg;
  logic [3:0] prev_sel;
  int         m_dig [4];
  int         m_err [4];
  bit         m_fill [4];
  bit         m_pres;
  logic [15:0] m_bcd;
  logic [3:0]  m_errv;
  bit          m_ovr;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic int model_dec(input logic [6:0] s);
    for (int k = 0; k < 10; k++)
      if (pat[k] == s) return k;
    return -1;
  endfunction

  task automatic model_reset();
    run_len  = 0;
    prev_seg = 7'd0;
    prev_sel = 4'd0;
    for (int k = 0; k < 4; k++) begin
      m_dig[k]  = 0;
      m_err[k]  = 0;
      m_fill[k] = 0;
    end
    m_pres = 0;
    m_bcd  = 16'd0;
    m_errv = 4'd0;
    m_ovr  = 0;
  endtask

  task automatic model_edge();
    bit oh;
    bit cap;
    bit all_f;
    int slot;
    int d;
    oh = ($countones(dig_sel) == 1);
    if (oh && seg_in == prev_seg && dig_sel == prev_sel)
      run_len++;
    else
      run_len = oh ? 1 : 0;
    if (run_len > 1000) run_len = 1000;
    cap = (run_len == N);
    prev_seg = seg_in;
    prev_sel = dig_sel;
    slot = 0;
    for (int k = 0; k < 4; k++)
      if (dig_sel[k]) slot = k;
    m_ovr = cap && m_pres;
    if (!m_pres) begin
      all_f = m_fill[0] && m_fill[1] && m_fill[2] && m_fill[3];
      if (all_f) begin
        m_pres = 1;
        for (int k = 0; k < 4; k++) begin
          m_bcd[k*4 +: 4] = 4'(m_dig[k]);
          m_errv[k]       = m_err[k][0];
        end
      end
      if (cap) begin
        d = model_dec(seg_in);
        m_dig[slot]  = (d < 0) ? 15 : d;
        m_err[slot]  = (d < 0) ? 1 : 0;
        m_fill[slot] = 1;
      end
    end else if (out_ready) begin
      m_pres = 0;
      for (int k = 0; k < 4; k++) m_fill[k] = 0;
    end
  endtask

  task automatic check_outs();
    chk("valid", 32'(out_valid), 32'(m_pres));
    chk("bcd", 32'(bcd_out), 32'(m_bcd));
    chk("err", 32'(err_out), 32'(m_errv));
    chk("overrun", 32'(overrun), 32'(m_ovr));
  endtask

  task automatic tick(input logic [6:0] s,
                      input logic [3:0] d,
                      input logic r);
    seg_in    = s;
    dig_sel   = d;
    out_ready = r;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outs();
  endtask

  task automatic hold(input logic [6:0] s,
                      input logic [3:0] d,
                      input logic r,
                      input int n);
    for (int k = 0; k < n; k++) tick(s, d, r);
  endtask

  task automatic fill4(input int d0, input int d1,
                       input int d2, input int d3);
    int dd [4];
    logic [3:0] sel;
    logic [6:0] p;
    dd = '{d0, d1, d2, d3};
    for (int k = 0; k < 4; k++) begin
      sel = 4'(1 << k);
      p = (dd[k] < 0) ? 7'd0 : pat[dd[k]];
      hold(p, sel, 1'b0, 6);
    end
  endtask

  initial begin
    pat = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
            7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
            7'b1111111, 7'b1111011};
    n_chk = 0;
    n_pass = 0;
    model_reset();
    rst_n = 1'b0;
    seg_in = 7'd0;
    dig_sel = 4'd0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_bcd", 32'(bcd_out), 32'd0);
    chk("rst_ovr", 32'(overrun), 32'd0);
    rst_n = 1'b1;

    // frame 1,2,3,4
    fill4(1, 2, 3, 4);
    hold(7'd0, 4'd0, 1'b0, 3);
    chk("f1_valid", 32'(out_valid), 32'd1);
    chk("f1_bcd", 32'(bcd_out), 32'h4321);
    chk("f1_err", 32'(err_out), 32'h0);
    tick(7'd0, 4'd0, 1'b1);
    chk("f1_drop", 32'(out_valid), 32'd0);

    // short run vs stable run, held long
    hold(pat[1], 4'b0001, 1'b0, 3);
    hold(pat[5], 4'b0010, 1'b0, 2);
    hold(pat[1], 4'b0001, 1'b0, 20);

    // blank slot 2
    hold(7'd0, 4'd0, 1'b0, 2);
    fill4(9, 8, -1, 7);
    hold(7'd0, 4'd0, 1'b0, 2);
    chk("f2_bcd", 32'(bcd_out), 32'h7F89);
    chk("f2_err", 32'(err_out), 32'b0100);

    // overrun in PRESENT, then handshake
    hold(pat[6], 4'b0010, 1'b0, 6);
    chk("ovr_bcd", 32'(bcd_out), 32'h7F89);
    tick(7'd0, 4'd0, 1'b1);

    // multi-hot strobe never captures
    hold(pat[3], 4'b0011, 1'b0, 10);

    // reset after three slots
    fill4(1, 2, 3, 0);
    seg_in  = 7'd0;
    dig_sel = 4'd0;
    fill4(5, 6, 7, 8);
    hold(7'd0, 4'd0, 1'b0, 1);
    hold(pat[1], 4'b0001, 1'b0, 6);
    hold(pat[2], 4'b0010, 1'b0, 6);
    hold(pat[3], 4'b0100, 1'b0, 6);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_bcd", 32'(bcd_out), 32'd0);
    chk("arst_err", 32'(err_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    hold(pat[4], 4'b1000, 1'b0, 8);
    chk("arst_nofr", 32'(out_valid), 32'd0);

    // random traffic
    for (int t = 0; t < 400; t++) begin
      logic [6:0] s;
      logic [3:0] d;
      int len;
      s = ($urandom_range(0, 9) < 7) ?
          pat[$urandom_range(0, 9)] : 7'($urandom);
      d = ($urandom_range(0, 9) < 8) ?
          4'(1 << $urandom_range(0, 3)) : 4'($urandom);
      len = $urandom_range(1, 8);
      for (int k = 0; k < len; k++)
        tick(s, d, 1'($urandom_range(0, 2) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
